// File: rtl/operand_entry.sv
// Keypad front end for the 2-digit BCD adder: shifts digit keys into operands A and B.
// Optional KEY_EDGE_DET_EN: treat key_valid as a debounced level and accept on its rising edge.
module operand_entry #(
  parameter logic [3:0] KEY_ADD = 4'hA,
  parameter logic [3:0] KEY_EQ  = 4'hE,
  parameter logic [3:0] KEY_CLR = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] store_s0,
  output logic [3:0] store_s1,
  output logic [3:0] store_s2,
  output logic [3:0] store_s3,
  output logic [1:0] state,
  output logic       result_valid,
  output logic       key_ack
);

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StResult = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic       result_valid_q, result_valid_d;
  logic       key_ack_q, key_ack_d;

  logic       strobe;
  logic [3:0] code;
  logic       is_digit;

`ifdef KEY_EDGE_DET_EN
  logic       valid_q;
  logic       strobe_q;
  logic [3:0] code_q;

  // Registered rising-edge detect; the code is delayed alongside so it lines up with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      code_q   <= 4'd0;
    end else begin
      valid_q  <= key_valid;
      strobe_q <= key_valid & ~valid_q;
      code_q   <= key_code;
    end
  end

  assign strobe = strobe_q;
  assign code   = code_q;
`else
  assign strobe = key_valid;
  assign code   = key_code;
`endif

  assign is_digit = (code <= 4'd9);

  always_comb begin
    state_d   = state_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    s3_d      = s3_q;
    key_ack_d = 1'b0;

    unique case (state_q)
      StEnterA, StEnterB, StResult: begin
        if (strobe) begin
          if (code == KEY_CLR) begin
            {s3_d, s2_d, s1_d, s0_d} = 16'h0000;
            state_d   = StEnterA;
            key_ack_d = 1'b1;
          end else begin
            unique case (state_q)
              StEnterA: begin
                if (is_digit) begin
                  s3_d      = s2_q;
                  s2_d      = code;
                  key_ack_d = 1'b1;
                end else if (code == KEY_ADD) begin
                  s1_d      = 4'd0;
                  s0_d      = 4'd0;
                  state_d   = StEnterB;
                  key_ack_d = 1'b1;
                end
              end
              StEnterB: begin
                if (is_digit) begin
                  s1_d      = s0_q;
                  s0_d      = code;
                  key_ack_d = 1'b1;
                end else if (code == KEY_EQ) begin
                  state_d   = StResult;
                  key_ack_d = 1'b1;
                end
              end
              default: begin
                // Result shown: a digit starts a fresh sum, commands leave operands frozen.
                if (is_digit) begin
                  {s3_d, s1_d, s0_d} = 12'h000;
                  s2_d      = code;
                  state_d   = StEnterA;
                  key_ack_d = 1'b1;
                end
              end
            endcase
          end
        end
      end
      default: begin
        {s3_d, s2_d, s1_d, s0_d} = 16'h0000;
        state_d = StEnterA;
      end
    endcase

    result_valid_d = (state_d == StResult);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StEnterA;
      s0_q           <= 4'd0;
      s1_q           <= 4'd0;
      s2_q           <= 4'd0;
      s3_q           <= 4'd0;
      result_valid_q <= 1'b0;
      key_ack_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      result_valid_q <= result_valid_d;
      key_ack_q      <= key_ack_d;
    end
  end

  assign store_s0     = s0_q;
  assign store_s1     = s1_q;
  assign store_s2     = s2_q;
  assign store_s3     = s3_q;
  assign state        = state_q;
  assign result_valid = result_valid_q;
  assign key_ack      = key_ack_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry; expectations adapt to KEY_EDGE_DET_EN.
module tb_operand_entry;

  localparam logic [3:0] KeyAdd = 4'hA;
  localparam logic [3:0] KeyEq  = 4'hE;
  localparam logic [3:0] KeyClr = 4'hF;

`ifdef KEY_EDGE_DET_EN
  localparam bit EdgeDet = 1'b1;
`else
  localparam bit EdgeDet = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] store_s0, store_s1, store_s2, store_s3;
  logic [1:0] state;
  logic       result_valid;
  logic       key_ack;

  int tests_run = 0;
  int tests_failed = 0;
  int ack_total = 0;
  int ack_mark;

  operand_entry dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .store_s0     (store_s0),
    .store_s1     (store_s1),
    .store_s2     (store_s2),
    .store_s3     (store_s3),
    .state        (state),
    .result_valid (result_valid),
    .key_ack      (key_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_ack) ack_total <= ack_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ops(input string tag, input logic [15:0] exp_ops, input logic [1:0] exp_st);
    check({tag, " operands"}, {16'h0, store_s3, store_s2, store_s1, store_s0}, {16'h0, exp_ops});
    check({tag, " state"}, {30'h0, state}, {30'h0, exp_st});
    check({tag, " result_valid"}, {31'h0, result_valid}, {31'h0, exp_st == 2'd2});
  endtask

  // One-cycle strobe then idle long enough for either latency mode to settle.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int exp_acks;
    logic [15:0] exp_hold;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(negedge clk);
    check_ops("reset", 16'h0000, 2'd0);
    check("reset key_ack", {31'h0, key_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // rst during entry
    press(4'd4);
    press(4'd7);
    check_ops("entry 47", 16'h4700, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_ops("rst mid entry", 16'h0000, 2'd0);
    check("rst mid entry key_ack", {31'h0, key_ack}, 32'd0);

    // Full sum 47 + 58
    ack_mark = ack_total;
    press(4'd4);
    press(4'd7);
    press(KeyAdd);
    check_ops("after add", 16'h4700, 2'd1);
    press(4'd5);
    press(4'd8);
    press(KeyEq);
    check_ops("full sum", 16'h4758, 2'd2);
    check("full sum acks", ack_total - ack_mark, 32'd6);

    // Ignored commands while showing the result
    ack_mark = ack_total;
    press(KeyAdd);
    press(KeyEq);
    check_ops("result frozen", 16'h4758, 2'd2);
    check("result frozen acks", ack_total - ack_mark, 32'd0);

    // Restart from result with a digit
    press(4'd9);
    check_ops("restart digit", 16'h0900, 2'd0);

    // Clear, then overflow digits
    press(KeyClr);
    check_ops("clear in A", 16'h0000, 2'd0);
    ack_mark = ack_total;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check_ops("overflow", 16'h2300, 2'd0);
    check("overflow acks", ack_total - ack_mark, 32'd3);

    // Ignored keys in ENTER_A and ENTER_B
    ack_mark = ack_total;
    press(KeyEq);
    press(4'hC);
    check_ops("ignored in A", 16'h2300, 2'd0);
    check("ignored in A acks", ack_total - ack_mark, 32'd0);
    press(KeyAdd);
    press(4'd5);
    ack_mark = ack_total;
    press(KeyAdd);
    press(4'hB);
    check_ops("ignored in B", 16'h2305, 2'd1);
    check("ignored in B acks", ack_total - ack_mark, 32'd0);

    // Clear from RESULT
    press(KeyEq);
    check_ops("result 23+05", 16'h2305, 2'd2);
    press(KeyClr);
    check_ops("clear in result", 16'h0000, 2'd0);

    // Held key: one accept with edge detect, one per cycle without
    ack_mark = ack_total;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd6;
    repeat (5) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_acks = EdgeDet ? 1 : 5;
    exp_hold = EdgeDet ? 16'h0600 : 16'h6600;
    check("hold acks", ack_total - ack_mark, exp_acks);
    check_ops("hold", exp_hold, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
